// File: rtl/alu_cmd_issuer_pkg.sv
// Shared definitions for the ALU command issuer and its sequencer:
// FSM encoding, opcode constants and default widths.
package alu_cmd_issuer_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  localparam logic [2:0] OP_XOR = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;

  function automatic int cmd_bits(input int width);
    return 3 + 2 * width;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// Synchronous FIFO for queued ALU commands; head entry is read combinationally.
module alu_cmd_issuer_cmd_fifo #(
  parameter int WIDTH_DATA = 11,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH_DATA-1:0]    din,
  output logic [WIDTH_DATA-1:0]    dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH_DATA-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues queued ALU commands to the sequencer one at a time and returns
// each result (or a timeout) through a valid/ready response register.
module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_op,
  input  logic [WIDTH-1:0]              cmd_a,
  input  logic [WIDTH-1:0]              cmd_b,
  output logic                          start,
  output logic [2:0]                    op_select,
  output logic [WIDTH-1:0]              operand_a,
  output logic [WIDTH-1:0]              operand_b,
  input  logic                          busy,
  input  logic                          result_valid,
  input  logic [WIDTH-1:0]              alu_result,
  input  logic                          zero_flag,
  input  logic                          carry_flag,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WIDTH-1:0]              rsp_result,
  output logic                          rsp_zero,
  output logic                          rsp_carry,
  output logic                          rsp_timeout,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_pending
);
  localparam int DW = cmd_bits(WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_cnt;
  logic            fifo_full, fifo_empty;
  logic            push, pop, tmo_hit;
  logic [DW-1:0]   fifo_dout;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign pop       = (state_q == ST_IDLE) && (state_d == ST_ISSUE);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign start     = (state_q == ST_ISSUE);
  assign rsp_valid = (state_q == ST_RESP);

  alu_cmd_issuer_cmd_fifo #(
    .WIDTH_DATA(DW),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  ({cmd_op, cmd_a, cmd_b}),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(cmd_pending)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (!fifo_empty && !busy && !rsp_valid) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_WAIT_RES;
      ST_WAIT_RES: if (result_valid || tmo_hit) state_d = ST_RESP;
      ST_RESP:     if (rsp_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tmo_cnt     <= '0;
      op_select   <= '0;
      operand_a   <= '0;
      operand_b   <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_carry   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) {op_select, operand_a, operand_b} <= fifo_dout;
      if (state_q == ST_ISSUE) tmo_cnt <= '0;
      else if (state_q == ST_WAIT_RES) tmo_cnt <= tmo_cnt + 1'b1;
      // a result arriving on the terminal-count cycle still counts as a result
      if (state_q == ST_WAIT_RES) begin
        if (result_valid) begin
          rsp_result  <= alu_result;
          rsp_zero    <= zero_flag;
          rsp_carry   <= carry_flag;
          rsp_timeout <= 1'b0;
        end else if (tmo_hit) begin
          rsp_result  <= '0;
          rsp_zero    <= 1'b0;
          rsp_carry   <= 1'b0;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a 3-cycle-latency sequencer model.
module tb_alu_cmd_issuer;
  import alu_cmd_issuer_pkg::*;

  localparam int W  = 4;
  localparam int D  = 2;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic start;
  logic [2:0] op_select;
  logic [W-1:0] operand_a, operand_b;
  logic busy, result_valid;
  logic [W-1:0] alu_result;
  logic zero_flag, carry_flag;
  logic rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic rsp_zero, rsp_carry, rsp_timeout;
  logic [$clog2(D):0] cmd_pending;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.WIDTH(W), .FIFO_DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .start(start),
    .op_select(op_select), .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .result_valid(result_valid), .alu_result(alu_result),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_carry(rsp_carry), .rsp_timeout(rsp_timeout), .cmd_pending(cmd_pending)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_start  = 0;
  int n_rsp    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // returns {result, zero, carry}
  function automatic logic [5:0] seq_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    case (op)
      OP_ADD:  s = {1'b0, a} + {1'b0, b};
      OP_AND:  s = {1'b0, a & b};
      OP_OR:   s = {1'b0, a | b};
      default: s = {1'b0, a ^ b};
    endcase
    return {s[3:0], s[3:0] == 4'd0, s[4]};
  endfunction

  // sequencer model: result_valid is sampled 3 edges after start is sampled
  logic mute = 1'b0;
  logic force_rv = 1'b0;
  logic rv_m;
  logic [1:0] lat;
  logic [5:0] res_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0; rv_m <= 1'b0; lat <= 2'd0; res_m <= 6'd0;
    end else begin
      rv_m <= 1'b0;
      if (start) begin
        busy  <= !mute;
        lat   <= 2'd1;
        res_m <= seq_fn(op_select, operand_a, operand_b);
      end else if (busy) begin
        if (lat == 2'd0) begin
          rv_m <= 1'b1;
          busy <= 1'b0;
        end else begin
          lat <= lat - 2'd1;
        end
      end
    end
  end

  assign result_valid = rv_m | force_rv;
  assign alu_result   = res_m[5:2];
  assign zero_flag    = res_m[1];
  assign carry_flag   = res_m[0];

  logic [6:0]  sb[$];
  logic [10:0] issued;

  always @(negedge clk) begin
    if (!rst) begin
      if (start) begin
        n_start++;
        check("start_while_busy", busy, 1'b0);
        check("start_while_rsp", rsp_valid, 1'b0);
        issued = {op_select, operand_a, operand_b};
      end
      if (rv_m) check("operands_stable", {op_select, operand_a, operand_b}, issued);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          check("rsp_fields", {rsp_result, rsp_zero, rsp_carry, rsp_timeout}, sb.pop_front());
          n_rsp++;
        end
      end
    end
  end

  task automatic push_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("push_ready_wait", cmd_ready, 1'b1);
    @(posedge clk);
    sb.push_back(mute ? 7'b0000001 : {seq_fn(op, a, b), 1'b0});
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("rsp_wait", rsp_valid, 1'b1);
  endtask

  task automatic wait_rsp_count(input int target);
    int n = 0;
    while (n_rsp < target && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("rsp_count", n_rsp, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int s0;
    logic [6:0] snap;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_pending", cmd_pending, 0);
    check("rst_start", start, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_operands", {op_select, operand_a, operand_b}, 0);
    check("rst_rsp_fields", {rsp_result, rsp_zero, rsp_carry, rsp_timeout}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single add command, latency checks
    push_cmd(3'b010, 4'h5, 4'h9);
    check("t1_no_start_yet", start, 1'b0);
    @(posedge clk); #1;
    check("t1_start", start, 1'b1);
    check("t1_op", op_select, 3'b010);
    check("t1_a", operand_a, 4'h5);
    check("t1_b", operand_b, 4'h9);
    wait_rsp(cyc);
    check("t1_rsp_latency", cyc + 1, 5);
    check("t1_result", rsp_result, 4'hE);
    check("t1_timeout", rsp_timeout, 1'b0);
    wait_rsp_count(1);

    // three back-to-back pushes
    s0 = n_start;
    push_cmd(OP_AND, 4'hC, 4'hA);
    push_cmd(OP_ADD, 4'h3, 4'h4);
    push_cmd(OP_OR,  4'h8, 4'h1);
    check("b2b_pending", cmd_pending, 2);
    check("b2b_ready_low", cmd_ready, 1'b0);
    wait_rsp_count(4);
    check("b2b_starts", n_start - s0, 3);

    // response back-pressure
    rsp_ready = 1'b0;
    push_cmd(OP_OR,  4'h2, 4'h4);
    push_cmd(OP_AND, 4'hF, 4'h3);
    wait_rsp(cyc);
    snap = {rsp_result, rsp_zero, rsp_carry, rsp_timeout};
    s0 = n_start;
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_fields", {rsp_result, rsp_zero, rsp_carry, rsp_timeout}, snap);
      check("stall_valid", rsp_valid, 1'b1);
    end
    check("stall_no_start", n_start, s0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_no_start", start, 1'b0);
    @(posedge clk); #1;
    check("post_hs_issue", start, 1'b1);
    wait_rsp_count(6);

    // fill the FIFO behind a stalled response, then drain in order
    rsp_ready = 1'b0;
    push_cmd(OP_XOR, 4'h6, 4'h3);
    push_cmd(OP_AND, 4'h7, 4'hE);
    push_cmd(OP_OR,  4'h1, 4'h2);
    check("full_pending", cmd_pending, 2);
    check("full_ready_low", cmd_ready, 1'b0);
    rsp_ready = 1'b1;
    push_cmd(3'd4, 4'hF, 4'h0);
    check("full_refill_pending", cmd_pending, 2);
    wait_rsp_count(10);

    // sequencer never answers
    mute = 1'b1;
    push_cmd(OP_ADD, 4'h1, 4'h1);
    push_cmd(OP_AND, 4'h1, 4'h1);
    cyc = 0;
    while (!start && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("tmo_start_seen", start, 1'b1);
    wait_rsp(cyc);
    check("tmo_latency", cyc, TO + 1);
    check("tmo_flag", rsp_timeout, 1'b1);
    check("tmo_result", rsp_result, 4'h0);
    wait_rsp_count(12);
    mute = 1'b0;

    // reset in the middle of WAIT_RES with two queued commands
    push_cmd(OP_ADD, 4'h1, 4'h2);
    push_cmd(OP_ADD, 4'h3, 4'h4);
    push_cmd(OP_ADD, 4'h5, 4'h6);
    check("pre_rst_pending", cmd_pending, 2);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_start", start, 1'b0);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_pending", cmd_pending, 0);
    check("rst_mid_ready", cmd_ready, 1'b1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    force_rv = 1'b1;
    @(posedge clk); #1;
    force_rv = 1'b0;
    s0 = n_start;
    repeat (8) begin
      @(posedge clk); #1;
      check("late_rv_ignored", rsp_valid, 1'b0);
    end
    check("late_rv_no_start", n_start, s0);

    // normal operation after reset, add with carry-out and zero result
    push_cmd(OP_ADD, 4'hF, 4'h1);
    wait_rsp_count(13);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator side of the ALU sequencer start/busy/result_valid handshake. Accepts ALU commands {op, a, b} on a valid/ready input and buffers them in a small FIFO. Issues one command at a time to the sequencer and holds operands stable for the whole transaction. Captures the one-cycle result/flags strobe into a response register with valid/ready output, and reports a timeout if the sequencer never answers.

Parameters:
WIDTH, 4, ALU operand/result width in bits
FIFO_DEPTH, 2, command FIFO entries (power of two, >=2)
TIMEOUT, 15, max cycles in WAIT_RES before a timeout response is produced (>=4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (not full)
cmd_op  input  3  ALU opcode
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
start  output  1  one-cycle start pulse to sequencer
op_select  output  3  opcode of the in-flight command
operand_a  output  WIDTH  operand A of the in-flight command
operand_b  output  WIDTH  operand B of the in-flight command
busy  input  1  sequencer busy
result_valid  input  1  sequencer result strobe (one cycle)
alu_result  input  WIDTH  ALU result, valid with result_valid
zero_flag  input  1  ALU zero flag, valid with result_valid
carry_flag  input  1  ALU carry flag, valid with result_valid
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  captured result
rsp_zero  output  1  captured zero flag
rsp_carry  output  1  captured carry flag
rsp_timeout  output  1  response is a timeout, not a real result
cmd_pending  output  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, active-high): FSM=IDLE; FIFO empty; cmd_pending=0; cmd_ready=1; start=0; op_select/operand_a/operand_b=0; rsp_valid=0; rsp_result/rsp_zero/rsp_carry/rsp_timeout=0; timeout counter=0.
- FIFO push: cmd_valid && cmd_ready. Pop: FSM leaves IDLE. Push and pop in the same cycle are allowed, including when full; occupancy is unchanged. cmd_ready = !full and is not relaxed by a same-cycle pop. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT_RES, RESP.
- IDLE -> ISSUE when FIFO non-empty && !busy && !rsp_valid. The head entry is popped and latched into op_select/operand_a/operand_b. The latched values hold until the next issue.
- ISSUE: start=1 for exactly this cycle. Go to WAIT_RES. Timeout counter is cleared.
- WAIT_RES: start=0 and the counter increments each cycle. On result_valid, capture alu_result/zero_flag/carry_flag into the rsp_* registers, set rsp_timeout=0 and go to RESP. If the counter reaches TIMEOUT first, set rsp_result=0, flags=0 and rsp_timeout=1, then go to RESP. If result_valid arrives on the same cycle as the terminal count, result_valid wins.
- RESP: rsp_valid=1, set on entry and held with the rsp_* fields until rsp_valid && rsp_ready. On that handshake rsp_valid clears and the FSM returns to IDLE. Earliest next issue is the cycle after.
- Nominal latency: the sequencer reports result_valid 3 cycles after start is sampled. Command accepted into an empty FIFO while idle: start 1 cycle later, rsp_valid 5 cycles after the push handshake.
- result_valid outside WAIT_RES is ignored.
- Only one command is in flight; a new command is never issued while rsp_valid=1.
- Reset mid-transaction: everything returns to reset values immediately and queued commands are discarded. The sequencer is reset by the same system reset.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, ISSUE=1, WAIT_RES=2, RESP=3), ALU opcode constants shared with the sequencer, and the default for WIDTH.
- One sub-module, cmd_fifo: a synchronous FIFO with parameters WIDTH_DATA=3+2*WIDTH and DEPTH, exposing full/empty/count. The top level holds the FSM, timeout counter and response register.

Test Plan:
- Single command op=3'b010, a=4'h5, b=4'h9 with a sequencer model (3-cycle latency, result 4'hE, zero=0, carry=0) -> one start pulse 1 cycle after accept; operands stable through result_valid; rsp_valid 5 cycles after accept with rsp_result=4'hE, rsp_timeout=0.
- Three back-to-back pushes (ops 1, 2, 3) with rsp_ready=1 -> cmd_ready drops after 2 pending; responses come back in order 1, 2, 3; exactly 3 start pulses, none overlapping busy.
- rsp_ready held 0 for 10 cycles after the first response -> rsp_* fields stable; no second start until the response handshake; next issue the cycle after handshake.
- result_valid tied 0 -> rsp_valid with rsp_timeout=1 and rsp_result=0 after TIMEOUT cycles in WAIT_RES; the FSM then serves the next queued command.
- FIFO full with a simultaneous push and pop (issue cycle) -> occupancy stays 2; no entry is lost or duplicated; pushed data is served in order.
- rst asserted during WAIT_RES with 2 commands queued -> start/rsp_valid=0 and cmd_pending=0 asynchronously; a late result_valid after reset release produces no response.
